// File: rtl/wordcount_beat_unpacker.sv
// Splits wide AXI4-Stream beats into fixed-width words, emitting exactly num_words per kick.
// Optional WORDCOUNT_UNPACK_SKIP_ZERO_EN: all-zero lanes are dropped as padding.
module wordcount_beat_unpacker #(
  parameter int unsigned C_BEAT_WIDTH  = 512,
  parameter int unsigned C_WORD_WIDTH  = 128,
  parameter int unsigned C_COUNT_WIDTH = 32
) (
  input  logic                     ap_clk,
  input  logic                     areset,
  input  logic                     kick,
  input  logic [C_COUNT_WIDTH-1:0] num_words,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [C_BEAT_WIDTH-1:0]  s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     m_word_valid,
  input  logic                     m_word_ready,
  output logic [C_WORD_WIDTH-1:0]  m_word_data,
  output logic                     m_word_last,
  output logic [C_COUNT_WIDTH-1:0] m_word_index
);

  localparam int unsigned LANES  = C_BEAT_WIDTH / C_WORD_WIDTH;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0]        LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE   = C_COUNT_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StEmit, StDrain, StDone} state_e;

  state_e                             r_state, w_state_next;
  logic [LANES-1:0][C_WORD_WIDTH-1:0] r_beat, w_beat_next;
  logic                               r_beat_last, w_beat_last_next;
  logic [LANE_W-1:0]                  r_lane, w_lane_next;
  logic [C_COUNT_WIDTH-1:0]           r_remaining, w_remaining_next;
  logic [C_COUNT_WIDTH-1:0]           r_index, w_index_next;
  logic                               r_underrun, w_underrun_next;

  logic [C_WORD_WIDTH-1:0] w_lane_data;
  logic w_skip, w_fire, w_final, w_advance, w_more, w_last_lane;

  assign w_lane_data = r_beat[r_lane];

`ifdef WORDCOUNT_UNPACK_SKIP_ZERO_EN
  assign w_skip = (r_state == StEmit) && (w_lane_data == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign m_word_valid = (r_state == StEmit) && !w_skip;
  assign m_word_data  = w_lane_data;
  assign m_word_last  = m_word_valid && (r_remaining == CNT_ONE);
  assign m_word_index = r_index;
  assign busy         = (r_state != StIdle);
  assign done         = (r_state == StDone);
  assign underrun     = r_underrun;

  assign w_fire      = m_word_valid && m_word_ready;
  assign w_final     = w_fire && (r_remaining == CNT_ONE);
  assign w_advance   = w_fire || w_skip;
  // A skipped lane leaves remaining untouched, so a further beat is still owed.
  assign w_more      = w_skip || (r_remaining > CNT_ONE);
  assign w_last_lane = (r_lane == LAST_LANE);

  always_comb begin
    w_state_next     = r_state;
    w_beat_next      = r_beat;
    w_beat_last_next = r_beat_last;
    w_lane_next      = r_lane;
    w_remaining_next = r_remaining;
    w_index_next     = r_index;
    w_underrun_next  = r_underrun;
    s_axis_tready    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (kick) begin
          w_remaining_next = num_words;
          w_index_next     = '0;
          w_underrun_next  = 1'b0;
          w_state_next     = (num_words == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          w_beat_next      = s_axis_tdata;
          w_beat_last_next = s_axis_tlast;
          w_lane_next      = '0;
          w_state_next     = StEmit;
        end
      end
      StEmit: begin
        // Gapless reload: take the next beat in the cycle the final lane leaves.
        s_axis_tready = w_last_lane && w_advance && w_more && !r_beat_last;
        if (w_fire) begin
          w_remaining_next = r_remaining - CNT_ONE;
          w_index_next     = r_index + CNT_ONE;
        end
        if (w_final) begin
          w_state_next = r_beat_last ? StDone : StDrain;
        end else if (w_advance) begin
          if (!w_last_lane) begin
            w_lane_next = r_lane + LANE_W'(1);
          end else if (r_beat_last) begin
            w_underrun_next = 1'b1;
            w_state_next    = StDone;
          end else if (s_axis_tvalid) begin
            w_beat_next      = s_axis_tdata;
            w_beat_last_next = s_axis_tlast;
            w_lane_next      = '0;
          end else begin
            w_state_next = StLoad;
          end
        end
      end
      StDrain: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state     <= StIdle;
      r_beat      <= '0;
      r_beat_last <= 1'b0;
      r_lane      <= '0;
      r_remaining <= '0;
      r_index     <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_beat      <= w_beat_next;
      r_beat_last <= w_beat_last_next;
      r_lane      <= w_lane_next;
      r_remaining <= w_remaining_next;
      r_index     <= w_index_next;
      r_underrun  <= w_underrun_next;
    end
  end

endmodule

// File: doc/wordcount_beat_unpacker.md
Name: wordcount_beat_unpacker

Overview:
Sits between the AXI read master's AXI4-Stream output and the word-count core. Takes 512-bit memory beats and splits each into C_BEAT_WIDTH/C_WORD_WIDTH fixed-width words, one word per cycle. It emits exactly num_words words per kick, flags the final word, and discards rounding padding and surplus beats.

Parameters:
C_BEAT_WIDTH, 512, input stream data width (bits).
C_WORD_WIDTH, 128, output word width; must divide C_BEAT_WIDTH; LANES = C_BEAT_WIDTH/C_WORD_WIDTH (default 4).
C_COUNT_WIDTH, 32, width of word counter and num_words.

Ports:
ap_clk  in  1  clock.
areset  in  1  synchronous active-high reset.
kick  in  1  start pulse; sampled only in IDLE.
num_words  in  C_COUNT_WIDTH  words to emit this run; latched on kick.
busy  out  1  high from cycle after accepted kick until DONE exits.
done  out  1  one-cycle pulse at end of run.
underrun  out  1  sticky until next kick; tlast arrived before num_words words were emitted.
s_axis_tvalid  in  1  beat valid.
s_axis_tready  out  1  beat accept.
s_axis_tdata  in  C_BEAT_WIDTH  beat data.
s_axis_tlast  in  1  last beat of transfer.
m_word_valid  out  1  word valid.
m_word_ready  in  1  downstream accept.
m_word_data  out  C_WORD_WIDTH  word; lane 0 = tdata[C_WORD_WIDTH-1:0] emitted first.
m_word_last  out  1  high with the num_words-th word.
m_word_index  out  C_COUNT_WIDTH  0-based index of current word.

Behaviour:
- Clock is ap_clk; reset is areset, synchronous, active-high. Reset values: all outputs 0, state IDLE, beat register invalid. A reset mid-run abandons the run: no done pulse, and the held beat is dropped.
- States are IDLE, LOAD, EMIT, DRAIN, DONE.
- IDLE:
  - kick with num_words>0 latches remaining=num_words, clears index and underrun, then goes to LOAD.
  - kick with num_words==0 goes straight to DONE; no beat is consumed.
- LOAD: s_axis_tready=1. On handshake: capture tdata and tlast, set lane=0, go to EMIT.
- EMIT:
  - m_word_valid=1 and m_word_data = lane slice.
  - On m_word handshake: remaining--, index++, lane++.
  - m_word_last = (remaining==1).
- Exits from EMIT:
  - Last word (remaining==1) handshaken: if the held beat had tlast, go to DONE; otherwise go to DRAIN. Unused lanes are discarded.
  - lane==LANES-1 handshaken and remaining>1, beat had tlast: set underrun, go to DONE.
  - lane==LANES-1 handshaken and remaining>1, no tlast: load the next beat.
- Gapless reload: during EMIT, s_axis_tready = (lane==LANES-1) & m_word_ready & (remaining>1) & ~held_tlast. A beat accepted in that cycle is captured with lane=0, so there is no bubble. Sustained rate is 1 word/cycle.
- DRAIN: s_axis_tready=1 and beats are discarded. A handshake with tlast goes to DONE. Not an error.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- kick is ignored while not in IDLE.
- Downstream stall (m_word_ready=0): data, index and last are held stable while valid. No combinational path from m_word_ready to m_word_data.
- remaining is C_COUNT_WIDTH unsigned. index wraps modulo 2^C_COUNT_WIDTH; this is not reachable in normal use.

Optional Feature:
Macro WORDCOUNT_UNPACK_SKIP_ZERO_EN.
- Defined: an all-zero lane is treated as padding. It is not presented on m_word (no valid), takes one cycle, and does not decrement remaining or advance index. The other lane-advance, reload and exit rules apply unchanged.
- Not defined: zero words are emitted like any other word.

Test Plan:
- num_words=8; 2 beats, words 0..7 = 0x10..0x17, second beat tlast; m_word_ready=1 -> 8 words in 8 consecutive cycles, values 0x10..0x17, index 0..7, last only on index 7, tready gapless, one done pulse, underrun=0.
- num_words=5; 2 beats, tlast on beat 2 -> 5 words, last on word 4, lanes 1..3 of beat 2 discarded, done, no DRAIN.
- num_words=4; 3 beats, tlast on beat 3 -> 4 words from beat 1, beats 2-3 drained (tready=1), done after tlast handshake, underrun=0.
- num_words=12; 2 beats, tlast on beat 2 -> 8 words, no m_word_last, underrun=1, done pulse.
- num_words=8; m_word_ready toggled 1,0,0,1 repeatedly; extra kick mid-run -> data, index and last stable during stalls; kick ignored; exactly 8 words.
- Reset asserted during EMIT at index 2; then kick with num_words=0 -> all outputs 0 after reset, no done from the aborted run; kick gives done the cycle after IDLE exit with no beat consumed. With WORDCOUNT_UNPACK_SKIP_ZERO_EN defined: beat with lane 1 = 0, num_words=3 -> words from lanes 0,2,3.
